imem_loader: RTL and testbench

Program loader that fills instruction memory through its port-A write path (`addr_a`, `addr_a_start`, `addr_a_write`), which is otherwise tied to zero.
- Accepts a byte stream over a valid/ready handshake: 16-bit little-endian word count, then data bytes, then a checksum byte.
- Packs the data bytes into little-endian 32-bit words and writes them to consecutive word addresses.
- While loading, holds the pipeline stopped so that `pc_adder` and `conveyor` do not fetch partially written code.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_word_packer.sv | 47 ++++
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    DONE
  } loader_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [7:0] CSUM_OK    = 8'h00;
  localparam logic [3:0] WE_ALL     = 4'b1111;

  // Return word with byte b placed in little-endian lane 'lane'.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  lane,
  output logic        full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;

  // Next lane contents and lane index; clear wins over a same-cycle accept.
  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (clear) begin
      word_d = '0;
      lane_d = '0;
    end else if (accept) begin
      word_d = merge_lane(word_q, lane_q, byte_in);
      lane_d = lane_q + 2'd1;
    end
  end

  // Lane storage and byte index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end

  assign word = word_q;
  assign lane = lane_q;
  // The byte being accepted right now is the last one of the word.
  assign full = accept && !clear && (lane_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives count/data/checksum bytes and writes words to IMEM port A.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] addr_a,
  output logic [3:0]  addr_a_start,
  output logic [31:0] addr_a_write,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  loader_state_t state_q, state_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [15:0]   rem_q, rem_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    csum_q, csum_d;
  logic          err_q, err_d;

  logic          byte_ready_q, byte_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    start_q, start_d;
  logic [31:0]   addr_a_q, addr_a_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          fire;
  logic [15:0]   count;
  logic [7:0]    csum_next;
  logic          pk_clear;
  logic          pk_accept;
  logic [31:0]   pk_word;
  logic [1:0]    pk_lane;
  logic          pk_full;

  assign fire      = byte_valid && byte_ready_q;
  assign count     = {byte_data, cnt_lo_q};
  assign csum_next = csum_q + byte_data;
  assign pk_clear  = (state_q == IDLE) && load_req;
  assign pk_accept = fire && (state_q == DATA);

  word_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pk_clear),
    .accept  (pk_accept),
    .byte_in (byte_data),
    .word    (pk_word),
    .lane    (pk_lane),
    .full    (pk_full)
  );

  // Next state, counters, checksum and the write address/data captured on entry to WRITE.
  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    err_d    = err_q;
    addr_a_d = addr_a_q;
    wdata_d  = wdata_q;
    if (fire) csum_d = csum_next;
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          csum_d  = '0;
          err_d   = 1'b0;
          state_d = LEN0;
        end
      end
      LEN0: begin
        if (fire) begin
          cnt_lo_d = byte_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (fire) begin
          if (count == 16'd0) begin
            state_d = CSUM;
          end else if ({16'd0, count} > MAX_WORDS[31:0]) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = count;
            addr_d  = BASE_ADDR;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (fire && pk_full) begin
          addr_a_d = addr_q;
          wdata_d  = merge_lane(pk_word, pk_lane, byte_data);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 32'(WORD_BYTES);
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? CSUM : DATA;
      end
      CSUM: begin
        if (fire) begin
          if (csum_next != CSUM_OK) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state so they align with it.
  always_comb begin
    byte_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                   (state_d == DATA) || (state_d == CSUM);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    start_d      = (state_d == WRITE) ? WE_ALL : 4'b0000;
  end

  // State, counter and output registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_lo_q     <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      csum_q       <= '0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_q      <= '0;
      addr_a_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_q      <= start_d;
      addr_a_q     <= addr_a_d;
      wdata_q      <= wdata_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign addr_a       = addr_a_q;
  assign addr_a_start = start_q;
  assign addr_a_write = wdata_q;
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [31:0] addr_a;
  logic [3:0]  addr_a_start;
  logic [31:0] addr_a_write;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  payload[$];
  logic [7:0]  stream[$];
  bit          exp_err;
  bit          timing_chk;
  bit          done_seen;
  int          exp_cycles;
  int          req_cyc;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .addr_a       (addr_a),
    .addr_a_start (addr_a_start),
    .addr_a_write (addr_a_write),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare process: every write and every done pulse checked against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (addr_a_start != 4'b0000) begin
        chk("write_enable", 32'(addr_a_start), 32'hF);
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", addr_a, addr_a_write);
        end else begin
          chk("write_addr", addr_a, exp_addr.pop_front());
          chk("write_data", addr_a_write, exp_data.pop_front());
        end
      end
      if (load_done) begin
        done_seen = 1'b1;
        chk("done_err", 32'(load_err), 32'(exp_err));
        chk("done_busy", 32'(load_busy), 32'd1);
        chk("pending_writes", 32'(exp_addr.size()), 32'd0);
        if (timing_chk) chk("load_cycles", 32'(cyc - req_cyc), 32'(exp_cycles));
      end
    end
  end

  // Reference model: stream bytes, expected writes, error and latency from the load rules.
  task automatic build_load(input int n, input bit bad, input bit oversize);
    logic [15:0] cnt;
    logic [7:0]  sum;
    stream.delete();
    cnt = oversize ? 16'(MAXW + 1) : 16'(n);
    stream.push_back(cnt[7:0]);
    stream.push_back(cnt[15:8]);
    if (oversize) begin
      exp_err    = 1'b1;
      exp_cycles = 3;
    end else begin
      if (payload.size() != 4 * n) begin
        payload.delete();
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
      end
      for (int w = 0; w < n; w++) begin
        exp_addr.push_back(BASE + 32'(4 * w));
        exp_data.push_back({payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]});
      end
      foreach (payload[i]) stream.push_back(payload[i]);
      sum = 8'h00;
      foreach (stream[i]) sum = sum + stream[i];
      stream.push_back(bad ? ((8'h00 - sum) ^ 8'h5A) : (8'h00 - sum));
      exp_err    = bad;
      exp_cycles = 2 + 5 * n + 2;
    end
    payload.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int duty, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      byte_valid = (int'($urandom_range(99)) < duty);
      byte_data  = b;
      ok = byte_valid && byte_ready;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: byte %h not accepted in 200 cycles", b);
    end
  endtask

  task automatic start_load();
    done_seen = 1'b0;
    load_req  = 1'b1;
    req_cyc   = cyc;
    @(negedge clk);
    load_req = 1'b0;
    chk("busy_after_req", 32'(load_busy), 32'd1);
    chk("err_cleared_by_req", 32'(load_err), 32'd0);
  endtask

  task automatic drive_load(input int duty);
    bit ok;
    timing_chk = (duty == 100);
    start_load();
    foreach (stream[i]) begin
      send_byte(stream[i], duty, ok);
      if (!ok) break;
    end
    for (int t = 0; t < 50 && !done_seen; t++) @(negedge clk);
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: load_done %0d, expected a pulse within 50 cycles", load_done);
    end
    @(negedge clk);
    chk("idle_busy", 32'(load_busy), 32'd0);
    chk("idle_ready", 32'(byte_ready), 32'd0);
    chk("idle_err_held", 32'(load_err), 32'(exp_err));
  endtask

  task automatic fixed_payload();
    payload.delete();
    for (int i = 1; i <= 8; i++) payload.push_back(8'(i * 17));
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_addr_a", addr_a, 32'd0);
    chk("rst_addr_a_start", 32'(addr_a_start), 32'd0);
    chk("rst_addr_a_write", addr_a_write, 32'd0);
    chk("rst_load_busy", 32'(load_busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two words 11..88, continuous; pin the model against hand-computed values.
    fixed_payload();
    build_load(2, 1'b0, 1'b0);
    chk("model_word0", exp_data[0], 32'h4433_2211);
    chk("model_word1", exp_data[1], 32'h8877_6655);
    chk("model_addr1", exp_addr[1], 32'h0000_0004);
    chk("model_trailer", 32'(stream[10]), 32'h9A);
    chk("model_cycles", 32'(exp_cycles), 32'd14);
    drive_load(100);

    // Empty load.
    build_load(0, 1'b0, 1'b0);
    chk("model_empty_trailer", 32'(stream[2]), 32'h00);
    drive_load(100);

    // One word, corrupted trailer: word still written, error sticky.
    build_load(1, 1'b1, 1'b0);
    drive_load(100);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(load_err), 32'd1);

    // Count above MAX_WORDS: no writes, done right after LEN1.
    build_load(0, 1'b0, 1'b1);
    chk("model_over_lo", 32'(stream[0]), 32'h01);
    chk("model_over_hi", 32'(stream[1]), 32'h04);
    drive_load(100);

    // Same data as the first load with 50% valid duty.
    fixed_payload();
    build_load(2, 1'b0, 1'b0);
    drive_load(50);

    // Reset after the second data byte, then a fresh load.
    fixed_payload();
    build_load(2, 1'b0, 1'b0);
    timing_chk = 1'b0;
    start_load();
    for (int i = 0; i < 4; i++) send_byte(stream[i], 100, ok);
    reset = 1'b0;
    #1;
    chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
    chk("midrst_addr_a_start", 32'(addr_a_start), 32'd0);
    chk("midrst_addr_a", addr_a, 32'd0);
    chk("midrst_load_busy", 32'(load_busy), 32'd0);
    chk("midrst_load_err", 32'(load_err), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    fixed_payload();
    build_load(2, 1'b0, 1'b0);
    drive_load(100);

    // Randomized loads.
    for (int it = 0; it < 10; it++) begin
      build_load(int'($urandom_range(5)), ($urandom_range(2) == 0), ($urandom_range(7) == 0));
      drive_load(($urandom_range(1) == 0) ? 100 : 50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
